// File: rtl/regfile_write_ctrl.sv
// Write-side controller for the 8x32 register block: in-order write queue, one commit per cycle,
// with forwarding of pending data. Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_write_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     hold,
    output logic [DW-1:0]            Din,
    output logic                     BE,
    output logic [(1<<AW)-1:0]       RE,
    input  logic [AW-1:0]            RA,
    input  logic [AW-1:0]            RB,
    output logic                     fwdA_hit,
    output logic [DW-1:0]            fwdA_data,
    output logic                     fwdB_hit,
    output logic [DW-1:0]            fwdB_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ACTIVE  = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [AW-1:0]   mem_addr_r [DEPTH];
    logic [DW-1:0]   mem_data_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            enq_s;
    logic            commit_s;
    logic [AW-1:0]   head_addr_s;
    logic [DW-1:0]   head_data_s;
    logic [PW-1:0]   fwd_idx_s;

    assign count       = count_r;
    assign wr_ready    = (count_r < CW'(DEPTH));
    assign push_s      = wr_valid & wr_ready;
    assign commit_s    = (count_r != CW'(0)) & ~hold;
    assign head_addr_s = mem_addr_r[rd_ptr_r];
    assign head_data_s = mem_data_r[rd_ptr_r];

`ifdef REGFILE_ZERO_REG_EN
    // Writes to the hardwired-zero register are acknowledged but dropped.
    assign enq_s = push_s & (wr_addr != {AW{1'b0}});
`else
    assign enq_s = push_s;
`endif

    // Queue storage: entry written at the tail on every accepted request.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_r[i] <= {AW{1'b0}};
                mem_data_r[i] <= {DW{1'b0}};
            end
        end else if (enq_s) begin
            mem_addr_r[wr_ptr_r] <= wr_addr;
            mem_data_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and commit leaves count unchanged.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (commit_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({enq_s, commit_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic tracking empty / draining / stalled.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (enq_s) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ACTIVE: begin
                if (hold) begin
                    state_next_s = STALLED;
                end else if (commit_s && (count_r == CW'(1)) && !enq_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            STALLED: begin
                if (!hold) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = STALLED;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Commit drive: head entry onto the block's bus when not stalled.
    always_comb begin
        BE  = 1'b0;
        RE  = {NR{1'b0}};
        Din = {DW{1'b0}};
        if (commit_s) begin
            BE  = 1'b1;
            RE  = NR'(1) << head_addr_s;
            Din = head_data_s;
        end else begin
            BE  = 1'b0;
        end
    end

    // Forwarding search, oldest to newest so the newest match overwrites earlier ones.
    always_comb begin
        fwdA_hit  = 1'b0;
        fwdA_data = {DW{1'b0}};
        fwdB_hit  = 1'b0;
        fwdB_data = {DW{1'b0}};
        fwd_idx_s = rd_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = rd_ptr_r + PW'(i);
            if (CW'(i) < count_r) begin
                if (mem_addr_r[fwd_idx_s] == RA) begin
                    fwdA_hit  = 1'b1;
                    fwdA_data = mem_data_r[fwd_idx_s];
                end else begin
                    fwdA_hit  = fwdA_hit;
                end
                if (mem_addr_r[fwd_idx_s] == RB) begin
                    fwdB_hit  = 1'b1;
                    fwdB_data = mem_data_r[fwd_idx_s];
                end else begin
                    fwdB_hit  = fwdB_hit;
                end
            end else begin
                fwdA_hit = fwdA_hit;
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (RA == {AW{1'b0}}) begin
            fwdA_hit  = 1'b1;
            fwdA_data = {DW{1'b0}};
        end else begin
            fwdA_hit  = fwdA_hit;
        end
        if (RB == {AW{1'b0}}) begin
            fwdB_hit  = 1'b1;
            fwdB_data = {DW{1'b0}};
        end else begin
            fwdB_hit  = fwdB_hit;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Self-checking bench for regfile_write_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_write_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          hold;
    logic [DW-1:0] Din;
    logic          BE;
    logic [7:0]    RE;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic          fwdA_hit;
    logic [DW-1:0] fwdA_data;
    logic          fwdB_hit;
    logic [DW-1:0] fwdB_data;
    logic [2:0]    count;

    regfile_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Clr(Clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .Din(Din), .BE(BE), .RE(RE),
        .RA(RA), .RB(RB), .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
        .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data), .count(count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] mregs [8];
    logic [DW-1:0] bregs [8];
    logic [DW-1:0] commit_log[$];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: in-order queue, pushes when not full, pops whenever non-empty and not held.
    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (q.size() > 0) && !hold;
            do_push = wr_valid && (q.size() < DEPTH);
`ifdef REGFILE_ZERO_REG_EN
            if (wr_addr == 3'd0) do_push = 1'b0;
`endif
            if (do_pop) begin
                mregs[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{addr: wr_addr, data: wr_data});
        end
    end

    // Stand-in for the register block, loading from the controller's outputs.
    always @(posedge Clk) begin
        if (BE) begin
            for (int n = 0; n < 8; n++) begin
                if (RE[n]) bregs[n] <= Din;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        bit            e_be, e_ha, e_hb;
        logic [7:0]    e_re;
        logic [DW-1:0] e_din, e_da, e_db;
        e_be  = (q.size() > 0) && !hold;
        e_re  = 8'h00;
        e_din = 32'h0;
        if (e_be) begin
            e_re  = 8'h01 << q[0].addr;
            e_din = q[0].data;
        end
        e_ha = 1'b0; e_da = 32'h0; e_hb = 1'b0; e_db = 32'h0;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (!e_ha && q[k].addr == RA) begin e_ha = 1'b1; e_da = q[k].data; end
            if (!e_hb && q[k].addr == RB) begin e_hb = 1'b1; e_db = q[k].data; end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (RA == 3'd0) begin e_ha = 1'b1; e_da = 32'h0; end
        if (RB == 3'd0) begin e_hb = 1'b1; e_db = 32'h0; end
`endif
        chk("m_count", count, q.size());
        chk("m_wr_ready", wr_ready, q.size() < DEPTH);
        chk("m_BE", BE, e_be);
        chk("m_RE", RE, e_re);
        chk("m_Din", Din, e_din);
        chk("m_fwdA", {fwdA_hit, fwdA_data}, {e_ha, e_da});
        chk("m_fwdB", {fwdB_hit, fwdB_data}, {e_hb, e_db});
        if (BE) commit_log.push_back(Din);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         accepted;
        int         tries;
        logic [7:0] exp_re;
        for (int n = 0; n < 8; n++) begin
            mregs[n] = 32'h0;
            bregs[n] = 32'h0;
        end
        Clr = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
        hold = 1'b0; RA = 3'd7; RB = 3'd6;
        #12;
        chk("rst_count", count, 3'd0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_BE", BE, 1'b0);
        chk("rst_RE", RE, 8'h00);
        chk("rst_Din", Din, 32'h0);
        chk("rst_fwdA", {fwdA_hit, fwdA_data}, 33'h0);
        @(negedge Clk);
        Clr = 1'b1;
        tick();

        // Single write, latency one cycle.
        wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t1_BE", BE, 1'b1);
        chk("t1_RE", RE, 8'h20);
        chk("t1_Din", Din, 32'hDEADBEEF);
        chk("t1_count", count, 3'd1);
        tick();
        #1;
        chk("t1_BE_after", BE, 1'b0);
        chk("t1_count_after", count, 3'd0);
        chk("t1_reg5", bregs[5], 32'hDEADBEEF);

        // Fill under hold, reject a fifth request, then drain in order.
        hold = 1'b1; RB = 3'd2;
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("t2_count_full", count, 3'd4);
        chk("t2_wr_ready", wr_ready, 1'b0);
        chk("t2_BE", BE, 1'b0);
        chk("t2_fwdB", {fwdB_hit, fwdB_data}, {1'b1, 32'h102});
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 32'h106;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t2_fifth_rejected", count, 3'd4);
        hold = 1'b0;
        #1;
        chk("t2_RE0", RE, 8'h02);
        for (int j = 1; j < 4; j++) begin
            tick();
            #1;
            exp_re = 8'h02 << j;
            chk("t2_RE_seq", RE, exp_re);
        end
        tick();
        #1;
        chk("t2_drained", count, 3'd0);

        // Two pending writes to one address: newest forwards, last write wins.
        hold = 1'b1; RA = 3'd3;
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t3_fwdA_hit", fwdA_hit, 1'b1);
        chk("t3_fwdA_data", fwdA_data, 32'h22);
        hold = 1'b0;
        tick();
        tick();
        #1;
        chk("t3_fwdA_after", fwdA_hit, 1'b0);
        chk("t3_reg3", bregs[3], 32'h22);

        // Wrap: sequence 0..9 with wr_valid held, one push per cycle once ready returns.
        commit_log.delete();
        hold = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_addr = AW'((i % 7) + 1); wr_data = 32'(i);
            if (i == 4) hold = 1'b0;
            accepted = 1'b0; tries = 0;
            while (!accepted && tries < 20) begin
                #1;
                accepted = wr_ready;
                tries++;
                tick();
            end
            if (!accepted) chk("t4_accept_timeout", 1'b0, 1'b1);
            if (i == 4) chk("t4_ready_return", tries, 2);
            if (i > 4) chk("t4_one_push_per_cycle", tries, 1);
        end
        wr_valid = 1'b0;
        tries = 0;
        while (count != 3'd0 && tries < 20) begin
            tick();
            tries++;
        end
        chk("t4_drain", count, 3'd0);
        chk("t4_log_size", commit_log.size(), 10);
        for (int k = 0; k < 10 && k < commit_log.size(); k++) begin
            chk("t4_order", commit_log[k], 32'(k));
        end

        // Reset in the middle of a drain with three pending.
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'hA0 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        hold = 1'b0;
        #1;
        chk("t5_pre_count", count, 3'd3);
        chk("t5_pre_BE", BE, 1'b1);
        Clr = 1'b0;
        #1;
        chk("t5_BE", BE, 1'b0);
        chk("t5_RE", RE, 8'h00);
        chk("t5_count", count, 3'd0);
        chk("t5_wr_ready", wr_ready, 1'b1);
        @(negedge Clk);
        Clr = 1'b1;
        commit_log.delete();
        for (int t = 0; t < 5; t++) tick();
        chk("t5_no_commits", commit_log.size(), 0);

`ifdef REGFILE_ZERO_REG_EN
        // Writes to register 0 are swallowed; reads of register 0 forward zero.
        commit_log.delete();
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t6_count", count, 3'd0);
        RA = 3'd0;
        #1;
        chk("t6_fwdA", {fwdA_hit, fwdA_data}, {1'b1, 32'h0});
        for (int t = 0; t < 3; t++) tick();
        chk("t6_no_BE", commit_log.size(), 0);
`else
        // Register 0 behaves like any other register.
        hold = 1'b1;
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 32'h55;
        tick();
        wr_valid = 1'b0;
        RA = 3'd0;
        #1;
        chk("t6_count", count, 3'd1);
        chk("t6_fwdA", {fwdA_hit, fwdA_data}, {1'b1, 32'h55});
        hold = 1'b0;
        tick();
        tick();
        chk("t6_reg0", bregs[0], 32'h55);
`endif

        for (int n = 0; n < 8; n++) chk("final_regs", bregs[n], mregs[n]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Write-side controller for the 8x32 register block.
- Accepts write requests (3-bit register address plus 32-bit data) over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle by driving the block's data bus, block enable and one-hot register enables.
- Forwards still-pending write data to the A/B read addresses so readers never see a stale value.

Parameters:
- DEPTH, 4, write-queue entries; power of 2, 2..16.
- AW, 3, register address width; the register block has 2^AW = 8 registers.
- DW, 32, data width.

Ports:
- Clk  input  1  rising-edge clock, shared with the register block
- Clr  input  1  asynchronous active-low reset
- wr_valid  input  1  write request valid
- wr_ready  output  1  queue can accept a request
- wr_addr  input  AW  destination register
- wr_data  input  DW  write data
- hold  input  1  stall: no commit this cycle
- Din  output  DW  data to the register block's in bus
- BE  output  1  block enable to the register block
- RE  output  8  one-hot register enables RE7..RE0 (bit n = RE n)
- RA  input  AW  read address A (same value the register block sees)
- RB  input  AW  read address B
- fwdA_hit  output  1  RA matches a pending write
- fwdA_data  output  DW  newest pending data for RA
- fwdB_hit  output  1  RB matches a pending write
- fwdB_data  output  DW  newest pending data for RB
- count  output  log2(DEPTH)+1  pending entries

Behaviour:
- Reset (Clr low, async):
  - count=0, read/write pointers=0, state=EMPTY.
  - BE=0, RE=0, Din=0, wr_ready=1, fwdA/B_hit=0, fwdA/B_data=0.
  - Pending entries are discarded, including on reset mid-drain.
- Queue storage and pointers are flops. Din, BE, RE, wr_ready and the fwd outputs are combinational from flops and inputs only.
- Push: wr_valid and wr_ready high at a Clk edge. wr_ready = (count < DEPTH). No pass-through when full, even if a commit happens in the same cycle.
- Commit cycle (count>0 and hold=0):
  - BE=1, RE=onehot(head.addr), Din=head.data.
  - The register block loads on the next Clk edge; head pops on that same edge.
- When count=0 or hold=1: BE=0, RE=0, Din=0.
- Simultaneous push and commit: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a request accepted at edge N is driven in cycle N+1 (if hold=0) and visible on the block's Aout/Bout after edge N+1.
- States:
  - EMPTY: count=0. Goes to ACTIVE on a push.
  - ACTIVE: count>0, hold=0. Goes to STALLED when hold=1; goes to EMPTY when the last entry commits with no push.
  - STALLED: count>0, hold=1. Goes to ACTIVE when hold=0.
  - A push while in STALLED stays in STALLED.
- Forwarding:
  - Search all valid entries, including the head being committed this cycle, for addr==RA (resp. RB).
  - The newest (closest to the tail) match wins; hit=1 and data=that entry's data.
  - No match gives hit=0, data=0.
  - An incoming request in the same cycle is not forwarded.
- Multiple pending writes to the same address all commit, in order. The final register value equals the newest write.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero (SPARC %g0).
  - A request with wr_addr=0 is accepted when wr_ready=1 but never enqueued; count is unchanged.
  - fwdA_hit=1 with fwdA_data=0 whenever RA=0; same for B.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then write addr=5, data=0xDEADBEEF, hold=0 -> next cycle BE=1, RE=0x20, Din=0xDEADBEEF; cycle after, BE=0 and count=0.
- hold=1; push 4 writes to addrs 1,2,3,4 -> count=4, wr_ready=0, BE=0; a 5th request is not accepted. Release hold -> RE goes 0x02, 0x04, 0x08, 0x10 on consecutive cycles.
- hold=1; push addr=3 data=0x11, then addr=3 data=0x22; RA=3 -> fwdA_hit=1, fwdA_data=0x22. After drain -> fwdA_hit=0 and register 3 reads 0x22.
- Full queue with hold=0 and wr_valid held high -> exactly one push per cycle after ready reasserts; pointers wrap with no lost or duplicated entry (sequence 0..9 committed in order).
- Assert Clr low mid-drain with count=3 -> immediately BE=0, RE=0, count=0, wr_ready=1; no further commits after release.
- REGFILE_ZERO_REG_EN defined: write addr=0 data=0xFFFFFFFF -> count stays 0, BE never asserts; RA=0 -> fwdA_hit=1, fwdA_data=0.
